alt_ddrx_reset_sequencer: RTL and testbench
===========================================

// Module: alt_ddrx_reset_sequencer
// PURPOSE
//  Reset generator for the DDR controller clock domain, succeeding the plain reset pass-through.
//  - Synchronises release of the async reset.
//  - Gates release on PHY calibration success.
//  - Releases NUM_RESET_OUTPUT fan-out resets in staggered order.
//  - Supports a soft-reset request/acknowledge handshake.
//  Sits between the PHY reset/calibration outputs and the controller sub-blocks.
// PARAMETERS
//  SYNC_STAGES        2   reset synchroniser depth, legal >= 2
//  NUM_RESET_OUTPUT   4   number of independent reset_n outputs, legal 1..16
//  RELEASE_GAP        8   ctl_clk cycles between release of output i and i+1, legal >= 1
//  SOFT_RESET_CYCLES  16  cycles outputs are held asserted on soft reset, legal >= 1
// PORTS
//  ctl_clk          in   1    controller clock (only clock)
//  ctl_reset_n      in   1    asynchronous, active-low reset
//  ctl_cal_success  in   1    PHY calibration passed, level, synchronous to ctl_clk
//  soft_reset_req   in   1    soft reset request, level, held high until ack
//  soft_reset_ack   out  1    one-cycle pulse: soft reset hold completed
//  resync_reset_n   out  NUM_RESET_OUTPUT  per-consumer active-low resets
//  ctl_ready        out  1    all outputs released, controller operational
//  reset_event_cnt  out  8    reset event counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset values
//  - ctl_reset_n low: all flops clear asynchronously.
//  - resync_reset_n=0, soft_reset_ack=0, ctl_ready=0, reset_event_cnt=0, state=RESET.
//  Synchroniser
//  - SYNC_STAGES-flop chain shifts in 1'b1.
//  - Chain output is high on rising edge SYNC_STAGES after deassertion.
//  - Reset assertion is asynchronous; release is synchronous.
//  FSM: RESET -> WAIT_CAL -> RELEASE -> RUN; RUN -> SOFT -> ACK -> WAIT_CAL; RUN -> WAIT_CAL
//  - RESET: exit to WAIT_CAL on the edge after the synchroniser output is high.
//  - WAIT_CAL: all outputs 0. When ctl_cal_success=1, go to RELEASE.
//    - The same edge releases resync_reset_n[0].
//  - RELEASE: gap counter of width clog2(RELEASE_GAP+1).
//    - Output i releases RELEASE_GAP*i cycles after output 0; released outputs stay 1.
//    - Release order is strictly index-ascending.
//    - One cycle after the last release: ctl_ready=1, go to RUN.
//    - NUM_RESET_OUTPUT=1: ctl_ready rises the cycle after out0 releases.
//  - RUN: ctl_ready=1, all outputs 1.
//    - soft_reset_req=1: go to SOFT.
//    - else ctl_cal_success=0: go to WAIT_CAL.
//    - Either exit drives all outputs to 0 and ctl_ready to 0 on the next edge.
//  - SOFT: holds for exactly SOFT_RESET_CYCLES cycles (down-counter), then goes to ACK.
//  - ACK: soft_reset_ack=1 for exactly one cycle, then go to WAIT_CAL.
//  Handshake and boundary rules
//  - A request is accepted only in RUN. A request raised in other states stays pending.
//  - After ack, a new request is accepted only once soft_reset_req has been sampled low.
//    - Track this with an armed flag, set in RESET.
//  - Soft request and cal loss in the same RUN cycle: soft path wins; ack is still issued.
//  - Cal loss during RELEASE: re-assert all outputs next edge, return to WAIT_CAL.
//    - Release restarts from output 0.
//  - Cal loss during SOFT/ACK: ignored; WAIT_CAL handles it.
//  - Async reset in any state: immediate return to the reset values above.
// CONFIGURATION
//  ALT_DDRX_RESET_EVENT_CNT_EN
//  - Defined: reset_event_cnt increments by 1 on each RUN->SOFT and RUN->WAIT_CAL transition.
//    - Saturates at 8'hFF. Clears only on ctl_reset_n.
//  - Undefined: reset_event_cnt tied to 8'h00; no counter logic inferred.
// TESTING (defaults; edge n = nth rising edge after ctl_reset_n deassert)
//  1 Power-up, cal held high -> out[0] rises edge 3, out[1] 11, out[2] 19, out[3] 27; ready edge 28.
//  2 Cal low until edge 40 -> all outputs 0 until then.
//    - out[0] rises edge 41; ready edge 66.
//  3 In RUN, soft_reset_req=1 sampled edge t, held high.
//    - Outputs 0 and ready 0 from t+1; ack pulse t+17 only; out[0] rises t+19.
//    - Req held high to t+30: no second ack.
//  4 In RUN, cal drops at edge t -> outputs 0 at t+1.
//    - Cal back at t+5: out[0] rises t+6, ready at t+31.
//    - With macro: reset_event_cnt = 1.
//  5 Soft req and cal drop in the same RUN cycle -> SOFT path taken; ack issued; cnt +1 only.
//  6 ctl_reset_n pulsed low mid-RELEASE (edge 15).
//    - Outputs and ready 0 asynchronously; sequence restarts per scenario 1.
//  7 Macro defined: 300 cal-loss events -> reset_event_cnt = 8'hFF.
//    - Macro undefined: reset_event_cnt = 8'h00 throughout.

Source files
------------

// File: rtl/alt_ddrx_reset_sequencer_if.sv
// Interface bundling the sequencer's calibration, soft-reset handshake and
// reset fan-out signals. The slave modport is the sequencer's view and the
// master modport is the view of the block that drives calibration and soft
// reset requests.
interface alt_ddrx_reset_sequencer_if #(
    parameter int NUM_RESET_OUTPUT = 4
);
    logic                        ctl_cal_success;
    logic                        soft_reset_req;
    logic                        soft_reset_ack;
    logic [NUM_RESET_OUTPUT-1:0] resync_reset_n;
    logic                        ctl_ready;
    logic [7:0]                  reset_event_cnt;

    modport master (
        output ctl_cal_success,
        output soft_reset_req,
        input  soft_reset_ack,
        input  resync_reset_n,
        input  ctl_ready,
        input  reset_event_cnt
    );

    modport slave (
        input  ctl_cal_success,
        input  soft_reset_req,
        output soft_reset_ack,
        output resync_reset_n,
        output ctl_ready,
        output reset_event_cnt
    );
endinterface

// File: rtl/alt_ddrx_reset_sequencer.sv
// Reset sequencer for the DDR controller clock domain.
// Synchronises release of ctl_reset_n, waits for PHY calibration, releases
// NUM_RESET_OUTPUT active-low resets in index order RELEASE_GAP cycles apart,
// and services a soft-reset request/acknowledge handshake.
// Optional feature macro: ALT_DDRX_RESET_EVENT_CNT_EN enables the saturating
// reset_event_cnt; without it the counter output is tied to zero.
module alt_ddrx_reset_sequencer #(
    parameter int SYNC_STAGES       = 2,
    parameter int NUM_RESET_OUTPUT  = 4,
    parameter int RELEASE_GAP       = 8,
    parameter int SOFT_RESET_CYCLES = 16
) (
    input  logic                          ctl_clk,
    input  logic                          ctl_reset_n,
    alt_ddrx_reset_sequencer_if.slave     rs
);

    localparam logic [2:0] ST_RESET    = 3'd0;
    localparam logic [2:0] ST_WAIT_CAL = 3'd1;
    localparam logic [2:0] ST_RELEASE  = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_SOFT     = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;

    localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
    localparam int IDX_W  = $clog2(NUM_RESET_OUTPUT + 1);
    localparam int SOFT_W = $clog2(SOFT_RESET_CYCLES + 1);

    localparam logic [NUM_RESET_OUTPUT-1:0] OUT_FIRST = NUM_RESET_OUTPUT'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_DONE  = IDX_W'(NUM_RESET_OUTPUT);
    localparam logic [SOFT_W-1:0] SOFT_LOAD = SOFT_W'(SOFT_RESET_CYCLES - 1);

    logic [SYNC_STAGES-1:0]      sync_chain;
    logic [2:0]                  state;
    logic [NUM_RESET_OUTPUT-1:0] out_n;
    logic                        ready;
    logic                        ack;
    logic                        armed;
    logic [GAP_W-1:0]            gap_cnt;
    logic [IDX_W-1:0]            rel_idx;
    logic [SOFT_W-1:0]           soft_cnt;
    logic                        soft_accept;

    // A request is taken only in RUN and only once the requester has been
    // seen low since the previous acknowledge.
    assign soft_accept = (state == ST_RUN) && rs.soft_reset_req && armed;

    // Reset synchroniser: asserts asynchronously, shifts in ones on release.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer FSM with release gap counter, soft-reset hold and handshake.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            state    <= ST_RESET;
            out_n    <= '0;
            ready    <= 1'b0;
            ack      <= 1'b0;
            armed    <= 1'b0;
            gap_cnt  <= '0;
            rel_idx  <= '0;
            soft_cnt <= '0;
        end else begin
            ack <= 1'b0;
            if (!rs.soft_reset_req) begin
                armed <= 1'b1;
            end
            case (state)
                ST_RESET: begin
                    armed <= 1'b1;
                    // Leave on the edge the synchroniser output rises.
                    if (sync_chain[SYNC_STAGES-2]) begin
                        state <= ST_WAIT_CAL;
                    end
                end
                ST_WAIT_CAL: begin
                    out_n <= '0;
                    ready <= 1'b0;
                    // Nothing releases before the synchroniser has fully settled.
                    if (rs.ctl_cal_success && sync_chain[SYNC_STAGES-1]) begin
                        out_n   <= OUT_FIRST;
                        gap_cnt <= '0;
                        rel_idx <= IDX_W'(1);
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!rs.ctl_cal_success) begin
                        out_n <= '0;
                        state <= ST_WAIT_CAL;
                    end else if (rel_idx == IDX_DONE) begin
                        ready <= 1'b1;
                        state <= ST_RUN;
                    end else if (gap_cnt == GAP_LAST) begin
                        out_n   <= out_n | (OUT_FIRST << rel_idx);
                        rel_idx <= rel_idx + IDX_W'(1);
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    // Soft request wins over a simultaneous calibration loss.
                    if (soft_accept) begin
                        armed    <= 1'b0;
                        out_n    <= '0;
                        ready    <= 1'b0;
                        soft_cnt <= SOFT_LOAD;
                        state    <= ST_SOFT;
                    end else if (!rs.ctl_cal_success) begin
                        out_n <= '0;
                        ready <= 1'b0;
                        state <= ST_WAIT_CAL;
                    end
                end
                ST_SOFT: begin
                    if (soft_cnt == '0) begin
                        ack   <= 1'b1;
                        state <= ST_ACK;
                    end else begin
                        soft_cnt <= soft_cnt - SOFT_W'(1);
                    end
                end
                ST_ACK: begin
                    state <= ST_WAIT_CAL;
                end
                default: begin
                    out_n <= '0;
                    ready <= 1'b0;
                    state <= ST_RESET;
                end
            endcase
        end
    end

`ifdef ALT_DDRX_RESET_EVENT_CNT_EN
    logic       run_exit;
    logic [7:0] event_cnt;

    assign run_exit = (state == ST_RUN) && (soft_accept || !rs.ctl_cal_success);

    // Saturating count of RUN exits; cleared only by ctl_reset_n.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            event_cnt <= 8'h00;
        end else if (run_exit && (event_cnt != 8'hFF)) begin
            event_cnt <= event_cnt + 8'h01;
        end
    end

    assign rs.reset_event_cnt = event_cnt;
`else
    assign rs.reset_event_cnt = 8'h00;
`endif

    assign rs.resync_reset_n = out_n;
    assign rs.ctl_ready      = ready;
    assign rs.soft_reset_ack = ack;

endmodule

// File: tb/tb_alt_ddrx_reset_sequencer.sv
// Directed testbench for alt_ddrx_reset_sequencer with default parameters.
// Edge n is the nth rising edge after ctl_reset_n deasserts; inputs change
// 1ns after an edge and outputs are sampled 1ns after an edge.
module tb_alt_ddrx_reset_sequencer;

    logic ctl_clk     = 1'b0;
    logic ctl_reset_n = 1'b0;

    always #5 ctl_clk = ~ctl_clk;

    alt_ddrx_reset_sequencer_if #(.NUM_RESET_OUTPUT(4)) rs_if ();

    alt_ddrx_reset_sequencer #(
        .SYNC_STAGES      (2),
        .NUM_RESET_OUTPUT (4),
        .RELEASE_GAP      (8),
        .SOFT_RESET_CYCLES(16)
    ) dut (
        .ctl_clk    (ctl_clk),
        .ctl_reset_n(ctl_reset_n),
        .rs         (rs_if)
    );

`ifdef ALT_DDRX_RESET_EVENT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int         total = 0;
    int         bad   = 0;
    int         cur   = 0;
    logic [7:0] exp_cnt = 8'h00;

    // Expected output vector when output 0 rises at edge e0 (0 = not yet scheduled).
    function automatic logic [3:0] exp_out(input int e0, input int n);
        logic [3:0] r;
        r = 4'h0;
        if (e0 > 0) begin
            for (int i = 0; i < 4; i++) begin
                if (n >= e0 + 8 * i) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] cnt_model();
        return CNT_EN ? exp_cnt : 8'h00;
    endfunction

    task automatic step();
        @(posedge ctl_clk);
        #1;
        cur++;
    endtask

    task automatic release_reset();
        @(negedge ctl_clk);
        ctl_reset_n = 1'b1;
        cur = 0;
    endtask

    task automatic test_reset();
        rs_if.ctl_cal_success = 1'b1;
        rs_if.soft_reset_req  = 1'b0;
        ctl_reset_n = 1'b0;
        exp_cnt = 8'h00;
        repeat (3) @(posedge ctl_clk);
        #1;
        total++; if (rs_if.resync_reset_n !== 4'h0) begin bad++; $display("FAIL reset_out actual=%h required=0", rs_if.resync_reset_n); end
        total++; if (rs_if.ctl_ready !== 1'b0) begin bad++; $display("FAIL reset_ready actual=%b required=0", rs_if.ctl_ready); end
        total++; if (rs_if.soft_reset_ack !== 1'b0) begin bad++; $display("FAIL reset_ack actual=%b required=0", rs_if.soft_reset_ack); end
        total++; if (rs_if.reset_event_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt actual=%h required=00", rs_if.reset_event_cnt); end
        release_reset();
    endtask

    // Runs edges 1..30 after a deassert with calibration held high.
    task automatic test_powerup();
        while (cur < 30) begin
            step();
            total++; if (rs_if.resync_reset_n !== exp_out(3, cur)) begin bad++; $display("FAIL powerup_out edge=%0d actual=%h required=%h", cur, rs_if.resync_reset_n, exp_out(3, cur)); end
            total++; if (rs_if.ctl_ready !== (cur >= 28)) begin bad++; $display("FAIL powerup_ready edge=%0d actual=%b required=%b", cur, rs_if.ctl_ready, cur >= 28); end
            total++; if (rs_if.soft_reset_ack !== 1'b0) begin bad++; $display("FAIL powerup_ack edge=%0d actual=%b required=0", cur, rs_if.soft_reset_ack); end
        end
    endtask

    task automatic test_soft_reset();
        int t;
        t = cur;
        rs_if.soft_reset_req = 1'b1;
        exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'h01;
        while (cur < t + 46) begin
            step();
            if (cur == t + 30) rs_if.soft_reset_req = 1'b0;
            total++; if (rs_if.resync_reset_n !== exp_out(t + 19, cur)) begin bad++; $display("FAIL soft_out edge=t+%0d actual=%h required=%h", cur - t, rs_if.resync_reset_n, exp_out(t + 19, cur)); end
            total++; if (rs_if.ctl_ready !== (cur >= t + 44)) begin bad++; $display("FAIL soft_ready edge=t+%0d actual=%b required=%b", cur - t, rs_if.ctl_ready, cur >= t + 44); end
            total++; if (rs_if.soft_reset_ack !== (cur == t + 17)) begin bad++; $display("FAIL soft_ack edge=t+%0d actual=%b required=%b", cur - t, rs_if.soft_reset_ack, cur == t + 17); end
        end
        total++; if (rs_if.reset_event_cnt !== cnt_model()) begin bad++; $display("FAIL soft_cnt actual=%h required=%h", rs_if.reset_event_cnt, cnt_model()); end
    endtask

    task automatic test_cal_loss();
        int t;
        t = cur;
        rs_if.ctl_cal_success = 1'b0;
        exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'h01;
        while (cur < t + 34) begin
            step();
            if (cur == t + 5) rs_if.ctl_cal_success = 1'b1;
            total++; if (rs_if.resync_reset_n !== exp_out(t + 6, cur)) begin bad++; $display("FAIL calloss_out edge=t+%0d actual=%h required=%h", cur - t, rs_if.resync_reset_n, exp_out(t + 6, cur)); end
            total++; if (rs_if.ctl_ready !== (cur >= t + 31)) begin bad++; $display("FAIL calloss_ready edge=t+%0d actual=%b required=%b", cur - t, rs_if.ctl_ready, cur >= t + 31); end
            total++; if (rs_if.soft_reset_ack !== 1'b0) begin bad++; $display("FAIL calloss_ack edge=t+%0d actual=%b required=0", cur - t, rs_if.soft_reset_ack); end
        end
        total++; if (rs_if.reset_event_cnt !== cnt_model()) begin bad++; $display("FAIL calloss_cnt actual=%h required=%h", rs_if.reset_event_cnt, cnt_model()); end
    endtask

    task automatic test_soft_and_cal_loss();
        int t;
        t = cur;
        rs_if.soft_reset_req  = 1'b1;
        rs_if.ctl_cal_success = 1'b0;
        exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'h01;
        while (cur < t + 46) begin
            step();
            if (cur == t + 17) rs_if.ctl_cal_success = 1'b1;
            if (cur == t + 20) rs_if.soft_reset_req = 1'b0;
            total++; if (rs_if.resync_reset_n !== exp_out(t + 19, cur)) begin bad++; $display("FAIL both_out edge=t+%0d actual=%h required=%h", cur - t, rs_if.resync_reset_n, exp_out(t + 19, cur)); end
            total++; if (rs_if.ctl_ready !== (cur >= t + 44)) begin bad++; $display("FAIL both_ready edge=t+%0d actual=%b required=%b", cur - t, rs_if.ctl_ready, cur >= t + 44); end
            total++; if (rs_if.soft_reset_ack !== (cur == t + 17)) begin bad++; $display("FAIL both_ack edge=t+%0d actual=%b required=%b", cur - t, rs_if.soft_reset_ack, cur == t + 17); end
        end
        total++; if (rs_if.reset_event_cnt !== cnt_model()) begin bad++; $display("FAIL both_cnt actual=%h required=%h", rs_if.reset_event_cnt, cnt_model()); end
    endtask

    task automatic test_cal_wait();
        ctl_reset_n = 1'b0;
        rs_if.ctl_cal_success = 1'b0;
        exp_cnt = 8'h00;
        repeat (2) @(posedge ctl_clk);
        release_reset();
        while (cur < 70) begin
            step();
            if (cur == 40) rs_if.ctl_cal_success = 1'b1;
            total++; if (rs_if.resync_reset_n !== exp_out(41, cur)) begin bad++; $display("FAIL calwait_out edge=%0d actual=%h required=%h", cur, rs_if.resync_reset_n, exp_out(41, cur)); end
            total++; if (rs_if.ctl_ready !== (cur >= 66)) begin bad++; $display("FAIL calwait_ready edge=%0d actual=%b required=%b", cur, rs_if.ctl_ready, cur >= 66); end
        end
    endtask

    task automatic test_reset_mid_release();
        ctl_reset_n = 1'b0;
        exp_cnt = 8'h00;
        repeat (2) @(posedge ctl_clk);
        release_reset();
        while (cur < 15) begin
            step();
            total++; if (rs_if.resync_reset_n !== exp_out(3, cur)) begin bad++; $display("FAIL midrel_pre_out edge=%0d actual=%h required=%h", cur, rs_if.resync_reset_n, exp_out(3, cur)); end
        end
        #1;
        ctl_reset_n = 1'b0;
        #1;
        total++; if (rs_if.resync_reset_n !== 4'h0) begin bad++; $display("FAIL midrel_async_out actual=%h required=0", rs_if.resync_reset_n); end
        total++; if (rs_if.ctl_ready !== 1'b0) begin bad++; $display("FAIL midrel_async_ready actual=%b required=0", rs_if.ctl_ready); end
        total++; if (rs_if.reset_event_cnt !== 8'h00) begin bad++; $display("FAIL midrel_async_cnt actual=%h required=00", rs_if.reset_event_cnt); end
        release_reset();
        test_powerup();
    endtask

    task automatic test_cnt_saturate();
        int waited;
        for (int ev = 0; ev < 300; ev++) begin
            rs_if.ctl_cal_success = 1'b0;
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'h01;
            step();
            rs_if.ctl_cal_success = 1'b1;
            waited = 0;
            while (rs_if.ctl_ready !== 1'b1 && waited < 40) begin
                step();
                waited++;
            end
            if (waited >= 40) begin
                total++; bad++;
                $display("FAIL cntsat_timeout event=%0d ready=%b required=1", ev, rs_if.ctl_ready);
                break;
            end
        end
        total++; if (rs_if.reset_event_cnt !== cnt_model()) begin bad++; $display("FAIL cntsat_cnt actual=%h required=%h", rs_if.reset_event_cnt, cnt_model()); end
        total++; if (rs_if.reset_event_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin bad++; $display("FAIL cntsat_final actual=%h required=%h", rs_if.reset_event_cnt, CNT_EN ? 8'hFF : 8'h00); end
    endtask

    initial begin
        rs_if.ctl_cal_success = 1'b0;
        rs_if.soft_reset_req  = 1'b0;
        test_reset();
        test_powerup();
        test_soft_reset();
        test_cal_loss();
        test_soft_and_cal_loss();
        test_cal_wait();
        test_reset_mid_release();
        test_cnt_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
